// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, instruction field positions and FSM states shared by the hazard/stall logic
package hazard_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LW = 5'b01000;
  localparam logic [4:0] OP_SW = 5'b00111;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;
  localparam int OPC_MSB = 31;
  localparam int ALUOP_MSB = 6;
  localparam int RD_MSB = 26;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;
endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: up-counter that sticks at all ones, cleared by synchronous reset
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH-1:0] value_q, value_d;
  always_comb value_d = (inc && value_q != '1) ? value_q + WIDTH'(1) : value_q;
  always_ff @(posedge clock) begin
    if (reset) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use detection, mult/div start/ready sequencing with watchdog,
// and stall/bubble generation for the FD/DX latches
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int IGNORE_R0  = 1,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             md_ready,
  output logic             stall,
  output logic             dx_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);
  localparam int TW = MD_TIMEOUT > 1 ? $clog2(MD_TIMEOUT) : 1;
  md_state_e state_q, state_d;
  logic [TW-1:0] cyc_q, cyc_d;
  logic timeout_q, timeout_d;
  logic [REG_W-1:0] dx_rd, fd_rs, fd_rt;
  logic [4:0] fd_op, fd_alu;
  logic fd_md, dx_load, fd_store, load_use, wd_fire;
  logic unused_bits;
  assign dx_rd = dx_ir[RD_MSB -: REG_W];
  assign fd_rs = fd_ir[RD_MSB-REG_W -: REG_W];
  assign fd_rt = fd_ir[RD_MSB-2*REG_W -: REG_W];
  assign fd_op = fd_ir[OPC_MSB -: 5];
  assign fd_alu = fd_ir[ALUOP_MSB -: 5];
  assign fd_md = fd_op == OP_RTYPE && (fd_alu == ALU_MUL || fd_alu == ALU_DIV);
  assign dx_load = dx_ir[OPC_MSB -: 5] == OP_LW;
  assign fd_store = fd_op == OP_SW;
  // A store's rt field is not read in decode, so it cannot create a load-use hazard
  assign load_use = dx_load && !(IGNORE_R0 != 0 && dx_rd == '0)
                    && (fd_rs == dx_rd || (fd_rt == dx_rd && !fd_store));
  assign wd_fire = MD_TIMEOUT != 0 && cyc_q == TW'(MD_TIMEOUT - 1);
  assign unused_bits = ^{fd_ir, dx_ir};
  always_comb begin
    state_d = state_q;
    timeout_d = timeout_q;
    md_start = 1'b0;
    stall = load_use;
    case (state_q)
      IDLE: begin
        stall = load_use || fd_md;
        md_start = fd_md && !load_use;
        state_d = md_start ? BUSY : IDLE;
      end
      BUSY: begin
        stall = 1'b1;
        state_d = (md_ready || wd_fire) ? DONE : BUSY;
        timeout_d = timeout_q || (!md_ready && wd_fire);
      end
      default: state_d = IDLE;
    endcase
    cyc_d = (state_q == BUSY && state_d == BUSY) ? cyc_q + TW'(1) : '0;
    stall = stall && !reset;
    md_start = md_start && !reset;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      timeout_q <= timeout_d;
    end
  end
  assign md_busy = state_q == BUSY;
  assign md_timeout = timeout_q;
  assign dx_bubble = stall;
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock(clock),
    .reset(reset),
    .inc(stall),
    .value(stall_count)
  );
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scenario tasks against a spec-level reference of hazards and stall accounting
module tb_hazard_stall_unit;
  logic clock = 1'b0, reset = 1'b1, md_ready = 1'b0;
  logic [31:0] fd_ir = '0, dx_ir = '0;
  logic a_stall, a_bubble, a_start, a_busy, a_timeout;
  logic b_stall, b_bubble, b_start, b_busy, b_timeout;
  logic [15:0] a_count;
  logic [2:0] b_count;
  int checks = 0, failures = 0, exp_cnt = 0;
  localparam logic [4:0] MUL = 5'b00110, DIV = 5'b00111, LW = 5'b01000, SW = 5'b00111;

  hazard_stall_unit #(.MD_TIMEOUT(8)) dut_a (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .md_ready(md_ready),
    .stall(a_stall), .dx_bubble(a_bubble), .md_start(a_start), .md_busy(a_busy),
    .md_timeout(a_timeout), .stall_count(a_count)
  );
  hazard_stall_unit #(.CNT_W(3)) dut_b (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir), .md_ready(md_ready),
    .stall(b_stall), .dx_bubble(b_bubble), .md_start(b_start), .md_busy(b_busy),
    .md_timeout(b_timeout), .stall_count(b_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] r_ins(input logic [4:0] alu, rd, rs, rt);
    return {5'b0, rd, rs, rt, 5'b0, alu, 2'b0};
  endfunction
  function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, rt);
    return {op, rd, rs, rt, 12'h0};
  endfunction
  function automatic bit ref_hazard(input logic [31:0] fd, dx);
    if (dx[31:27] != 5'd8 || dx[26:22] == 5'd0) return 1'b0;
    if (fd[21:17] == dx[26:22]) return 1'b1;
    return fd[16:12] == dx[26:22] && fd[31:27] != 5'd7;
  endfunction

  task automatic tick(input bit exp_stall);
    if (exp_stall) exp_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    fd_ir = r_ins(MUL, 5'd1, 5'd2, 5'd3);
    dx_ir = i_ins(LW, 5'd2, 5'd0, 5'd0);
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", a_stall); end
    checks++; if (a_bubble !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%0d exp=0", a_bubble); end
    checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%0d exp=0", a_start); end
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (a_count !== 16'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", a_count); end
    checks++; if (b_count !== 3'd0) begin failures++; $display("FAIL rst_count_b got=%0d exp=0", b_count); end
    checks++; if (a_timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%0d exp=0", a_timeout); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", a_busy); end
    reset = 1'b0;
    fd_ir = '0;
    dx_ir = '0;
    exp_cnt = 0;
  endtask

  task automatic test_load_use;
    dx_ir = i_ins(LW, 5'd3, 5'd0, 5'd0);
    fd_ir = r_ins(5'd0, 5'd1, 5'd3, 5'd5);
    #1;
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0d exp=1", a_stall); end
    checks++; if (a_bubble !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%0d exp=1", a_bubble); end
    tick(1'b1);
    checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", a_count, exp_cnt); end
    dx_ir = '0;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%0d exp=0", a_stall); end
    tick(1'b0);
    dx_ir = i_ins(LW, 5'd4, 5'd0, 5'd0);
    fd_ir = i_ins(SW, 5'd0, 5'd7, 5'd4);
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL lu_store_rt got=%0d exp=0", a_stall); end
    fd_ir = i_ins(SW, 5'd0, 5'd4, 5'd9);
    #1;
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL lu_store_rs got=%0d exp=1", a_stall); end
    tick(1'b1);
    dx_ir = i_ins(LW, 5'd0, 5'd0, 5'd0);
    fd_ir = r_ins(5'd0, 5'd1, 5'd0, 5'd0);
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL lu_r0 got=%0d exp=0", a_stall); end
    tick(1'b0);
    checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL lu_count2 got=%0d exp=%0d", a_count, exp_cnt); end
  endtask

  task automatic test_random_decode;
    logic [31:0] fd, dx;
    bit exp;
    for (int i = 0; i < 60; i++) begin
      fd = $urandom;
      dx = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        dx[31:27] = LW;
        if ($urandom_range(1, 0) == 1) fd[21:17] = dx[26:22];
        else fd[16:12] = dx[26:22];
        if ($urandom_range(3, 0) == 0) fd[31:27] = SW;
        if ($urandom_range(7, 0) == 0) dx[26:22] = 5'd0;
      end
      if (fd[31:27] == 5'd0 && fd[6:3] == 4'b0011) fd[6] = 1'b1;
      fd_ir = fd;
      dx_ir = dx;
      exp = ref_hazard(fd, dx);
      #1;
      checks++; if (a_stall !== exp) begin failures++; $display("FAIL rnd_stall fd=%h dx=%h got=%0d exp=%0d", fd, dx, a_stall, exp); end
      checks++; if (a_bubble !== exp) begin failures++; $display("FAIL rnd_bubble got=%0d exp=%0d", a_bubble, exp); end
      checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL rnd_start got=%0d exp=0", a_start); end
      tick(exp);
      checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", a_count, exp_cnt); end
    end
    fd_ir = '0;
    dx_ir = '0;
  endtask

  task automatic test_mult(input int d, input bit exp_to);
    int c0;
    c0 = exp_cnt;
    dx_ir = '0;
    fd_ir = r_ins((d % 2 == 0) ? DIV : MUL, 5'd6, 5'd1, 5'd2);
    md_ready = 1'b0;
    #1;
    checks++; if (a_start !== 1'b1) begin failures++; $display("FAIL md_start got=%0d exp=1", a_start); end
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL md_start_stall got=%0d exp=1", a_stall); end
    tick(1'b1);
    for (int k = 1; k <= d; k++) begin
      md_ready = (k == d);
      #1;
      checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL md_busy k=%0d got=%0d exp=1", k, a_busy); end
      checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL md_stall k=%0d got=%0d exp=1", k, a_stall); end
      checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL md_single_start k=%0d got=%0d exp=0", k, a_start); end
      tick(1'b1);
    end
    md_ready = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL md_done_stall got=%0d exp=0", a_stall); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL md_done_busy got=%0d exp=0", a_busy); end
    checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL md_done_start got=%0d exp=0", a_start); end
    checks++; if (a_timeout !== exp_to) begin failures++; $display("FAIL md_timeout got=%0d exp=%0d", a_timeout, exp_to); end
    tick(1'b0);
    fd_ir = '0;
    #1;
    checks++; if (a_busy !== 1'b0 || a_stall !== 1'b0) begin failures++; $display("FAIL md_idle busy=%0d stall=%0d exp=0", a_busy, a_stall); end
    checks++; if (a_count !== 16'(exp_cnt) || exp_cnt - c0 != d + 1) begin failures++; $display("FAIL md_count got=%0d exp=%0d", a_count, c0 + d + 1); end
    tick(1'b0);
  endtask

  task automatic test_back_to_back;
    logic [4:0] r;
    r = 5'($urandom_range(31, 1));
    dx_ir = i_ins(LW, r, 5'd0, 5'd0);
    fd_ir = r_ins(MUL, 5'd9, r, 5'd0);
    #1;
    checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL b2b_lu_start got=%0d exp=0", a_start); end
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL b2b_lu_stall got=%0d exp=1", a_stall); end
    tick(1'b1);
    dx_ir = '0;
    #1;
    checks++; if (a_start !== 1'b1) begin failures++; $display("FAIL b2b_start1 got=%0d exp=1", a_start); end
    tick(1'b1);
    md_ready = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy1 got=%0d exp=1", a_busy); end
    tick(1'b1);
    md_ready = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0 || a_start !== 1'b0) begin failures++; $display("FAIL b2b_done stall=%0d start=%0d exp=0", a_stall, a_start); end
    tick(1'b0);
    fd_ir = r_ins(DIV, 5'd10, 5'd11, 5'd12);
    #1;
    checks++; if (a_start !== 1'b1) begin failures++; $display("FAIL b2b_start2 got=%0d exp=1", a_start); end
    tick(1'b1);
    md_ready = 1'b1;
    #1;
    tick(1'b1);
    md_ready = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL b2b_done2 got=%0d exp=0", a_stall); end
    tick(1'b0);
    fd_ir = '0;
    tick(1'b0);
    checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", a_count, exp_cnt); end
  endtask

  task automatic test_timeout;
    int n;
    dx_ir = '0;
    fd_ir = r_ins(DIV, 5'd1, 5'd2, 5'd3);
    md_ready = 1'b0;
    #1;
    checks++; if (a_start !== 1'b1) begin failures++; $display("FAIL to_start got=%0d exp=1", a_start); end
    tick(1'b1);
    n = 0;
    while (a_busy === 1'b1 && n < 20) begin
      n++;
      tick(1'b1);
    end
    checks++; if (n != 8) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=8", n); end
    checks++; if (a_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%0d exp=1", a_timeout); end
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL to_release got=%0d exp=0", a_stall); end
    tick(1'b0);
    fd_ir = '0;
    tick(1'b0);
    checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL to_count got=%0d exp=%0d", a_count, exp_cnt); end
    test_mult(3, 1'b1);
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    checks++; if (a_timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%0d exp=0", a_timeout); end
    test_mult(8, 1'b0);
  endtask

  task automatic test_reset_busy;
    dx_ir = '0;
    fd_ir = r_ins(MUL, 5'd1, 5'd2, 5'd3);
    md_ready = 1'b0;
    #1;
    tick(1'b1);
    tick(1'b1);
    reset = 1'b1;
    #1;
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL rb_stall got=%0d exp=0", a_stall); end
    checks++; if (a_start !== 1'b0) begin failures++; $display("FAIL rb_start got=%0d exp=0", a_start); end
    tick(1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    fd_ir = '0;
    md_ready = 1'b1;
    #1;
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rb_busy got=%0d exp=0", a_busy); end
    checks++; if (a_stall !== 1'b0 || a_start !== 1'b0) begin failures++; $display("FAIL rb_idle stall=%0d start=%0d exp=0", a_stall, a_start); end
    checks++; if (a_count !== 16'd0) begin failures++; $display("FAIL rb_count got=%0d exp=0", a_count); end
    tick(1'b0);
    md_ready = 1'b0;
    fd_ir = r_ins(MUL, 5'd1, 5'd2, 5'd3);
    #1;
    checks++; if (a_busy !== 1'b0 || a_start !== 1'b1) begin failures++; $display("FAIL rb_late_ready busy=%0d start=%0d exp=0/1", a_busy, a_start); end
    tick(1'b1);
    md_ready = 1'b1;
    #1;
    tick(1'b1);
    md_ready = 1'b0;
    tick(1'b0);
    fd_ir = '0;
    tick(1'b0);
    checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL rb_count2 got=%0d exp=%0d", a_count, exp_cnt); end
  endtask

  task automatic test_saturation;
    int e;
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    exp_cnt = 0;
    dx_ir = i_ins(LW, 5'd5, 5'd0, 5'd0);
    fd_ir = r_ins(5'd0, 5'd1, 5'd5, 5'd2);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      e = (i > 7) ? 7 : i;
      checks++; if (b_count !== 3'(e)) begin failures++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, b_count, e); end
      checks++; if (a_count !== 16'(exp_cnt)) begin failures++; $display("FAIL sat_wide i=%0d got=%0d exp=%0d", i, a_count, exp_cnt); end
    end
    dx_ir = '0;
    fd_ir = '0;
    tick(1'b0);
    checks++; if (b_count !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", b_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_load_use();
    test_random_decode();
    test_mult(5, 1'b0);
    test_mult(int'($urandom_range(7, 1)), 1'b0);
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
